led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Parametrised multi-channel LED pattern generator. It replaces the fixed 4-LED 1 Hz toggler. It drives NUM_LEDS board LEDs in one of four runtime-selectable modes: blink, chase, bounce and PWM breathe. A shared prescaler sets the pattern step rate. The block sits in the PL top level, with mode and enable driven from PS GPIO or board keys.

Parameters:
NUM_LEDS, 4, number of LED outputs; legal range 1..32.
PERIOD_CYCLES, 50_000_000, sys_clk cycles per pattern step (tick); must be ≥2.
PWM_BITS, 8, width of the breathe PWM counter and duty register.
BREATHE_DIV, 195_312, sys_clk cycles per breathe duty step; must be ≥1.

Ports:
sys_clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  1 = run; 0 = LEDs off and all state cleared.
mode  in  2  0 BLINK, 1 CHASE, 2 BOUNCE, 3 BREATHE.
led  out  NUM_LEDS  LED drive, active high.
tick  out  1  one-cycle pulse on each pattern step.

Behaviour:
- Reset: the following registers clear to 0: led, tick, prescaler, breathe divider, pwm_cnt, duty, bounce dir. The pattern register clears to 0.
- Prescaler: counts 0..PERIOD_CYCLES-1.
  - tick is registered and asserts for exactly one cycle in the cycle after the count reaches PERIOD_CYCLES-1.
  - The count wraps to 0 on that same edge.
- Mode change (mode differs from the registered previous mode) or en rising:
  - Prescaler, breathe divider, pwm_cnt, duty and dir clear.
  - The pattern register loads the new mode's initial value on the next edge.
  - No tick is emitted in that cycle.
- en=0: led=0, tick=0, all counters held at 0.
- BLINK: initial pattern all zeros; each tick inverts all bits (all-on / all-off alternating).
- CHASE:
  - Initial pattern 1 (LSB set).
  - Each tick rotates left by one.
  - MSB wraps to LSB.
  - NUM_LEDS=1 stays 1.
- BOUNCE:
  - Initial pattern 1, dir=up.
  - Each tick shifts toward MSB while up and toward LSB while down.
  - dir flips when the shift lands on MSB or LSB, so the end LEDs are lit for one tick each (no double dwell).
  - Sequence for 4 LEDs: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - NUM_LEDS=1 stays 1.
- BREATHE:
  - pwm_cnt free-runs mod 2^PWM_BITS.
  - All LEDs = (pwm_cnt < duty), registered, so led lags pwm_cnt by 1 cycle.
  - Every BREATHE_DIV cycles, duty steps by ±1. The ramp goes 0 → 2^PWM_BITS-1 → 0, reversing at each extreme with no hold.
  - duty=0 gives fully off; the maximum duty gives 2^PWM_BITS-1 on-cycles per PWM period.
  - tick still pulses at the prescaler rate but does not affect duty.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asserting rst_n low mid-pattern clears everything immediately (asynchronous); release resumes from the initial state of the current mode.

Optional Feature:
LED_SYNC_IN_EN
- Defined: en and mode each pass through a 2-flop synchroniser (reset 0) before use. This adds 2 cycles of latency from an input change to the mode-change clear.
- Undefined: en and mode are used directly, and they must be synchronous to sys_clk.

Decomposition:
- Shared package led_pkg holds:
  - the mode encodings MODE_BLINK=2'd0, MODE_CHASE=2'd1, MODE_BOUNCE=2'd2, MODE_BREATHE=2'd3;
  - the mode typedef;
  - a clog2-based width helper for the prescaler.
- One sub-module: led_tick_div, a parametrised divider with inputs clr and en and a registered one-cycle pulse output. It is instantiated twice: once with PERIOD_CYCLES for tick and once with BREATHE_DIV for duty steps.

Test Plan:
All scenarios use NUM_LEDS=4, PERIOD_CYCLES=10, PWM_BITS=4, BREATHE_DIV=2, macro undefined unless stated.
1. Reset mid-run: hold rst_n low, release, en=1, mode=0 → led=0000, then a tick every 10 cycles; led toggles 1111/0000 on successive ticks.
2. CHASE for 5 ticks → led 0001, 0010, 0100, 1000, 0001; tick is exactly 1 cycle wide.
3. BOUNCE for 8 ticks → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. BREATHE → duty counts 0..15..0 in steps every 2 cycles. At duty=0, led=0000 for a full 16-cycle PWM period. At duty=15, led is 1111 for 15 of 16 cycles.
5. Switch CHASE→BOUNCE at pattern 0100 mid-period → next edge pattern=0001 and the prescaler restarts; the first tick follows 10 cycles later. Drop en → led=0000 the next cycle.
6. With LED_SYNC_IN_EN defined, change mode at cycle N → pattern reloads at edge N+3 (2 synchroniser flops + 1 register).

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg
// Shared definitions for the LED pattern generator: the mode encodings and
// the counter-width helper used by the step dividers.
// No ports.

package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  // Bits needed to hold a count of 0..div-1; never less than one bit.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// led_tick_div
// Clock divider producing a registered one-cycle pulse every DIV enabled
// cycles. The count runs 0..DIV-1; the pulse appears in the cycle after the
// count reaches DIV-1, and the count wraps on that same edge.
// Ports:
//   sys_clk  in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear of count and pulse (has priority)
//   en       in   count enable; count holds while low
//   pulse    out  one-cycle pulse per DIV cycles

module led_tick_div #(
  parameter int DIV = 10
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic pulse
);
  import led_pkg::*;

  localparam int             W    = cnt_width(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        pulse <= 1'b1;
      end else begin
        cnt   <= cnt + 1'b1;
        pulse <= 1'b0;
      end
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
// Multi-channel LED pattern generator with four runtime-selectable modes.
//
//   mode | meaning
//   -----+---------------------------------------------------------------
//   0    | BLINK   all LEDs toggle together on every tick
//   1    | CHASE   single lit LED rotates toward MSB, wraps to LSB
//   2    | BOUNCE  single lit LED walks to MSB and back, no dwell at ends
//   3    | BREATHE all LEDs PWM'd, duty ramps 0..max..0 every BREATHE_DIV
//
// Ports:
//   sys_clk  in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   1 = run, 0 = LEDs off and all state cleared
//   mode     in   pattern select (table above)
//   led      out  LED drive, active high, registered
//   tick     out  one-cycle pulse per pattern step, registered
//
// Build option: define LED_SYNC_IN_EN to pass en and mode through 2-flop
// synchronisers; otherwise both must already be synchronous to sys_clk.

module led_pattern_ctrl #(
  parameter int NUM_LEDS      = 4,
  parameter int PERIOD_CYCLES = 50_000_000,
  parameter int PWM_BITS      = 8,
  parameter int BREATHE_DIV   = 195_312
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);
  import led_pkg::*;

  localparam logic [NUM_LEDS-1:0] ONE  = NUM_LEDS'(1);
  localparam logic [PWM_BITS-1:0] DMAX = '1;

  logic      en_s;
  led_mode_e mode_s;

`ifdef LED_SYNC_IN_EN
  // mode bits are synchronised independently; a skewed transition only
  // produces an extra restart, which is harmless.
  logic [1:0] en_sync;
  logic [1:0] mode_sync0, mode_sync1;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync    <= '0;
      mode_sync0 <= '0;
      mode_sync1 <= '0;
    end else begin
      en_sync    <= {en_sync[0], en};
      mode_sync0 <= mode;
      mode_sync1 <= mode_sync0;
    end
  end

  assign en_s   = en_sync[1];
  assign mode_s = led_mode_e'(mode_sync1);
`else
  assign en_s   = en;
  assign mode_s = led_mode_e'(mode);
`endif

  logic                en_q;
  led_mode_e           mode_q;
  logic                restart;
  logic                div_clr;
  logic                duty_step;
  logic [NUM_LEDS-1:0] pattern, pattern_nxt;
  logic                dir, dir_nxt;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_nxt;
  logic [PWM_BITS-1:0] duty, duty_nxt;

  assign restart = en_s && (!en_q || (mode_s != mode_q));
  assign div_clr = !en_s || restart;

  led_tick_div #(.DIV(PERIOD_CYCLES)) u_tick_div (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (div_clr),
    .en      (en_s),
    .pulse   (tick)
  );

  led_tick_div #(.DIV(BREATHE_DIV)) u_breathe_div (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (div_clr),
    .en      (en_s),
    .pulse   (duty_step)
  );

  // dir is shared: bounce direction in BOUNCE, ramp direction in BREATHE.
  always_comb begin
    pattern_nxt = pattern;
    dir_nxt     = dir;
    pwm_nxt     = pwm_cnt;
    duty_nxt    = duty;
    if (!en_s) begin
      pattern_nxt = '0;
      dir_nxt     = 1'b0;
      pwm_nxt     = '0;
      duty_nxt    = '0;
    end else if (restart) begin
      pattern_nxt = (mode_s == MODE_CHASE || mode_s == MODE_BOUNCE) ? ONE : '0;
      dir_nxt     = 1'b0;
      pwm_nxt     = '0;
      duty_nxt    = '0;
    end else begin
      case (mode_s)
        MODE_BLINK: begin
          if (tick) pattern_nxt = ~pattern;
        end
        MODE_CHASE: begin
          if (tick) pattern_nxt = (pattern << 1) | (pattern >> (NUM_LEDS - 1));
        end
        MODE_BOUNCE: begin
          if (tick && NUM_LEDS > 1) begin
            if (!dir) begin
              pattern_nxt = pattern << 1;
              if (pattern_nxt[NUM_LEDS-1]) dir_nxt = 1'b1;
            end else begin
              pattern_nxt = pattern >> 1;
              if (pattern_nxt[0]) dir_nxt = 1'b0;
            end
          end
        end
        default: begin
          pwm_nxt = pwm_cnt + 1'b1;
          if (duty_step) begin
            if (!dir) begin
              duty_nxt = duty + 1'b1;
              if (duty_nxt == DMAX) dir_nxt = 1'b1;
            end else begin
              duty_nxt = duty - 1'b1;
              if (duty_nxt == '0) dir_nxt = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      mode_q  <= MODE_BLINK;
      pattern <= '0;
      dir     <= 1'b0;
      pwm_cnt <= '0;
      duty    <= '0;
      led     <= '0;
    end else begin
      en_q    <= en_s;
      mode_q  <= mode_s;
      pattern <= pattern_nxt;
      dir     <= dir_nxt;
      pwm_cnt <= pwm_nxt;
      duty    <= duty_nxt;
      if (en_s && !restart && mode_s == MODE_BREATHE)
        led <= {NUM_LEDS{pwm_cnt < duty}};
      else
        led <= pattern_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  localparam int N = 4;
`ifdef LED_SYNC_IN_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic         sys_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic         en      = 1'b0;
  logic [1:0]   mode    = 2'd0;
  logic [N-1:0] led;
  logic         tick;

  always #5 sys_clk = ~sys_clk;

  led_pattern_ctrl #(
    .NUM_LEDS      (N),
    .PERIOD_CYCLES (10),
    .PWM_BITS      (4),
    .BREATHE_DIV   (2)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .led     (led),
    .tick    (tick)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Counts negedges until tick is seen high; gives up after 40.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge sys_clk);
      cycles++;
    end while (tick !== 1'b1 && cycles < 40);
  endtask

  function automatic int tri_duty(input int s);
    int m;
    m = s % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  function automatic int duty_after(input int e);
    return (e == 0) ? 0 : tri_duty((e - 1) / 2);
  endfunction

  typedef struct {
    logic [1:0]   mode;
    int           step;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int iv;
    logic exp_on;

    vecs[0]  = '{2'd0, 0, 4'b0000};
    vecs[1]  = '{2'd0, 1, 4'b1111};
    vecs[2]  = '{2'd0, 2, 4'b0000};
    vecs[3]  = '{2'd0, 3, 4'b1111};
    vecs[4]  = '{2'd1, 0, 4'b0001};
    vecs[5]  = '{2'd1, 1, 4'b0010};
    vecs[6]  = '{2'd1, 2, 4'b0100};
    vecs[7]  = '{2'd1, 3, 4'b1000};
    vecs[8]  = '{2'd1, 4, 4'b0001};
    vecs[9]  = '{2'd2, 0, 4'b0001};
    vecs[10] = '{2'd2, 1, 4'b0010};
    vecs[11] = '{2'd2, 2, 4'b0100};
    vecs[12] = '{2'd2, 3, 4'b1000};
    vecs[13] = '{2'd2, 4, 4'b0100};
    vecs[14] = '{2'd2, 5, 4'b0010};
    vecs[15] = '{2'd2, 6, 4'b0001};
    vecs[16] = '{2'd2, 7, 4'b0010};

    cyc(3);
    check("reset_led", led, 4'b0000);
    check("reset_tick", tick, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].step == 0) begin
        en = 1'b0;
        cyc(2 + L);
        check($sformatf("en_off_led[%0d]", i), led, 4'b0000);
        mode = vecs[i].mode;
        en   = 1'b1;
        cyc(1 + L);
        check($sformatf("init_led[%0d]", i), led, vecs[i].exp);
      end else begin
        wait_tick(iv);
        check($sformatf("tick_interval[%0d]", i), iv, (vecs[i].step == 1) ? 10 : 9);
        cyc(1);
        check($sformatf("tick_width[%0d]", i), tick, 1'b0);
        check($sformatf("pattern_led[%0d]", i), led, vecs[i].exp);
      end
    end

    // Mid-period switch CHASE -> BOUNCE, then drop en.
    en = 1'b0;
    cyc(2 + L);
    mode = 2'd1;
    en   = 1'b1;
    cyc(1 + L);
    for (int k = 0; k < 2; k++) begin
      wait_tick(iv);
      cyc(1);
    end
    check("switch_pre_led", led, 4'b0100);
    cyc(4);
    mode = 2'd2;
    cyc(L);
    check("switch_hold_led", led, 4'b0100);
    cyc(1);
    check("switch_reload_led", led, 4'b0001);
    wait_tick(iv);
    check("switch_first_tick", iv, 10);
    cyc(1);
    check("switch_step_led", led, 4'b0010);
    en = 1'b0;
    cyc(1 + L);
    check("en_drop_led", led, 4'b0000);
    cyc(1);
    check("en_drop_tick", tick, 1'b0);

    // Asynchronous reset mid-pattern, release resumes at mode's initial state.
    mode = 2'd1;
    en   = 1'b1;
    cyc(1 + L);
    wait_tick(iv);
    cyc(1);
    check("prereset_led", led, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", led, 4'b0000);
    check("async_reset_tick", tick, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1 + L);
    check("post_reset_led", led, 4'b0001);

    // BREATHE: compare every cycle against the triangular duty ramp.
    en = 1'b0;
    cyc(2 + L);
    mode = 2'd3;
    en   = 1'b1;
    cyc(1 + L);
    check("breathe_e0_led", led, 4'b0000);
    for (int e = 1; e <= 72; e++) begin
      cyc(1);
      exp_on = (((e - 1) % 16) < duty_after(e - 1));
      check($sformatf("breathe_led[e=%0d]", e), led, {N{exp_on}});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
